// File: rtl/dm_pkg.sv
// Shared encodings and helpers for the data-memory stage.
package dm_pkg;

  localparam int DM_DEPTH_WORDS = 1024;

  typedef enum logic [2:0] {
    WOP_WORD   = 3'b000,
    WOP_HALF_U = 3'b001,
    WOP_HALF_S = 3'b010,
    WOP_BYTE_U = 3'b011,
    WOP_BYTE_S = 3'b100
  } wop_e;

  function automatic logic wop_legal(input logic [2:0] w);
    return w <= 3'b100;
  endfunction

  // Bytes never misalign; halves need an even address, words a 4-byte boundary.
  function automatic logic wop_misaligned(input logic [2:0] w, input logic [1:0] lo);
    logic m;
    m = 1'b0;
    case (w)
      WOP_WORD:               m = |lo;
      WOP_HALF_U, WOP_HALF_S: m = lo[0];
      default:                m = 1'b0;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/dm_lane.sv
// Byte-lane steering: store byte enables and merge, load select and extension.
module dm_lane
  import dm_pkg::*;
(
  input  logic [2:0]  width_op,
  input  logic [1:0]  lane,
  input  logic [31:0] wd,
  input  logic [31:0] old_word,
  output logic [3:0]  be,
  output logic [31:0] merged,
  output logic [31:0] ld_data
);

  logic [31:0] wd_rep;
  logic [15:0] half_sel;
  logic [7:0]  byte_sel;

  // Replicate store data across lanes so the byte enables alone pick the target.
  always_comb begin
    be     = 4'b0000;
    wd_rep = wd;
    case (width_op)
      WOP_WORD: begin
        be     = 4'b1111;
        wd_rep = wd;
      end
      WOP_HALF_U, WOP_HALF_S: begin
        be     = lane[1] ? 4'b1100 : 4'b0011;
        wd_rep = {2{wd[15:0]}};
      end
      WOP_BYTE_U, WOP_BYTE_S: begin
        be     = 4'b0001 << lane;
        wd_rep = {4{wd[7:0]}};
      end
      default: begin
        be     = 4'b0000;
        wd_rep = wd;
      end
    endcase
  end

  always_comb begin
    merged = old_word;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) merged[8*i +: 8] = wd_rep[8*i +: 8];
    end
  end

  always_comb begin
    half_sel = lane[1] ? old_word[31:16] : old_word[15:0];
    byte_sel = 8'h00;
    case (lane)
      2'd0:    byte_sel = old_word[7:0];
      2'd1:    byte_sel = old_word[15:8];
      2'd2:    byte_sel = old_word[23:16];
      default: byte_sel = old_word[31:24];
    endcase
  end

  always_comb begin
    ld_data = 32'h0;
    case (width_op)
      WOP_WORD:   ld_data = old_word;
      WOP_HALF_U: ld_data = {16'h0, half_sel};
      WOP_HALF_S: ld_data = {{16{half_sel[15]}}, half_sel};
      WOP_BYTE_U: ld_data = {24'h0, byte_sel};
      WOP_BYTE_S: ld_data = {{24{byte_sel[7]}}, byte_sel};
      default:    ld_data = 32'h0;
    endcase
  end

endmodule

// File: rtl/dm_stage.sv
// Data-memory stage: word RAM with byte/half/word access, address-error flags
// and a store trace tap (trace_* nets) for the grader.
module dm_stage
  import dm_pkg::*;
#(
  parameter int DEPTH_WORDS = DM_DEPTH_WORDS,
  parameter int AW          = $clog2(DEPTH_WORDS)
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] addr,
  input  logic [31:0] wd,
  input  logic        mem_write,
  input  logic        mem_read,
  input  logic [2:0]  width_op,
  input  logic [31:0] pc,
  output logic [31:0] rd,
  output logic        ades,
  output logic        adel
);

  logic [31:0]   mem_q [DEPTH_WORDS];
  logic [31:0]   wr_word_d;
  logic [AW-1:0] widx;
  logic [1:0]    lane;
  logic [31:0]   old_word, merged, ld_data;
  logic [3:0]    be;
  logic          misalign, oor, bad_op, acc_err, we;

  logic          trace_vld;
  logic [31:0]   trace_pc, trace_addr, trace_data;

  assign widx     = addr[AW+1:2];
  assign lane     = addr[1:0];
  assign old_word = mem_q[widx];

  dm_lane u_lane (
    .width_op (width_op),
    .lane     (lane),
    .wd       (wd),
    .old_word (old_word),
    .be       (be),
    .merged   (merged),
    .ld_data  (ld_data)
  );

  always_comb begin
    misalign = wop_misaligned(width_op, lane);
    oor      = addr[31:AW+2] != '0;
    bad_op   = !wop_legal(width_op);
    acc_err  = misalign | oor | bad_op;
    ades     = mem_write & acc_err;
    adel     = mem_read & acc_err;
    rd       = (mem_read && !acc_err) ? ld_data : 32'h0;
  end

  // Reset wins over a store in the same cycle.
  always_comb begin
    we        = mem_write & ~acc_err & reset & (|be);
    wr_word_d = merged;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH_WORDS; i++) mem_q[i] <= '0;
    end else if (we) begin
      mem_q[widx] <= wr_word_d;
    end
  end

  always_comb begin
    trace_vld  = we;
    trace_pc   = pc;
    trace_addr = {addr[31:2], 2'b00};
    trace_data = wr_word_d;
  end

endmodule

// File: tb/tb_dm_stage.sv
// Directed bench for dm_stage: expected responses and store traces are queued
// by the stimulus and checked by an independent monitor.
module tb_dm_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] addr, wd, pc;
  logic        mem_write, mem_read;
  logic [2:0]  width_op;
  logic [31:0] rd;
  logic        ades, adel;

  typedef struct {
    logic [31:0] rd;
    logic        ades;
    logic        adel;
    string       nm;
  } exp_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] a;
    logic [31:0] d;
  } tr_t;

  exp_t exp_q[$];
  tr_t  tr_q[$];
  exp_t e;
  tr_t  t;
  int   n_chk  = 0;
  int   n_pass = 0;
  logic [31:0] pc_r = 32'h0040_0000;

  always #5 clk = ~clk;

  dm_stage dut (
    .clk       (clk),
    .reset     (reset),
    .addr      (addr),
    .wd        (wd),
    .mem_write (mem_write),
    .mem_read  (mem_read),
    .width_op  (width_op),
    .pc        (pc),
    .rd        (rd),
    .ades      (ades),
    .adel      (adel)
  );

  task automatic op(input string nm, input logic rs, input logic w, input logic r,
                    input logic [2:0] wop, input logic [31:0] a, input logic [31:0] d,
                    input logic [31:0] erd, input logic eades, input logic eadel,
                    input logic etr, input logic [31:0] etw);
    @(negedge clk);
    pc_r      = pc_r + 32'd4;
    reset     = rs;
    mem_write = w;
    mem_read  = r;
    width_op  = wop;
    addr      = a;
    wd        = d;
    pc        = pc_r;
    exp_q.push_back('{erd, eades, eadel, nm});
    if (etr) tr_q.push_back('{pc_r, {a[31:2], 2'b00}, etw});
  endtask

  // Monitor: samples just after the negedge drive, away from the active edge.
  always @(negedge clk) begin
    #1;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      n_chk++;
      if (rd === e.rd && ades === e.ades && adel === e.adel) n_pass++;
      else $display("FAIL %s: got rd=%h ades=%b adel=%b, want rd=%h ades=%b adel=%b",
                    e.nm, rd, ades, adel, e.rd, e.ades, e.adel);
    end
    if (dut.trace_vld === 1'b1) begin
      $display("@%h: *%h <= %h", dut.trace_pc, dut.trace_addr, dut.trace_data);
      n_chk++;
      if (tr_q.size() == 0) begin
        $display("FAIL trace: unexpected store @%h *%h <= %h",
                 dut.trace_pc, dut.trace_addr, dut.trace_data);
      end else begin
        t = tr_q.pop_front();
        if (dut.trace_pc === t.pc && dut.trace_addr === t.a && dut.trace_data === t.d) n_pass++;
        else $display("FAIL trace: got @%h *%h <= %h, want @%h *%h <= %h",
                      dut.trace_pc, dut.trace_addr, dut.trace_data, t.pc, t.a, t.d);
      end
    end
  end

  localparam logic [2:0] W = 3'b000, HU = 3'b001, HS = 3'b010, BU = 3'b011, BS = 3'b100;

  initial begin
    reset = 1'b0; mem_write = 1'b0; mem_read = 1'b0;
    width_op = W; addr = '0; wd = '0; pc = '0;

    op("rst_idle0",   0, 0, 0, W, 32'h0,   32'h0, 32'h0, 0, 0, 0, 32'h0);
    op("rst_idle1",   0, 0, 0, W, 32'h0,   32'h0, 32'h0, 0, 0, 0, 32'h0);
    op("rst_ld10",    0, 0, 1, W, 32'h10,  32'h0, 32'h0, 0, 0, 0, 32'h0);
    op("st10",        1, 1, 0, W, 32'h10,  32'hDEADBEEF, 32'h0, 0, 0, 1, 32'hDEADBEEF);
    op("ld10",        1, 0, 1, W, 32'h10,  32'h0, 32'hDEADBEEF, 0, 0, 0, 32'h0);
    op("ld10_in_rst", 0, 0, 1, W, 32'h10,  32'h0, 32'hDEADBEEF, 0, 0, 0, 32'h0);
    op("ld10_clr",    1, 0, 1, W, 32'h10,  32'h0, 32'h0, 0, 0, 0, 32'h0);
    op("st20",        1, 1, 0, W, 32'h20,  32'h12345678, 32'h0, 0, 0, 1, 32'h12345678);
    op("ld20",        1, 0, 1, W, 32'h20,  32'h0, 32'h12345678, 0, 0, 0, 32'h0);
    op("sb23",        1, 1, 0, BU, 32'h23, 32'h000000AB, 32'h0, 0, 0, 1, 32'hAB345678);
    op("ld20_b",      1, 0, 1, W, 32'h20,  32'h0, 32'hAB345678, 0, 0, 0, 32'h0);
    op("sh20",        1, 1, 0, HU, 32'h20, 32'h0000CDEF, 32'h0, 0, 0, 1, 32'hAB34CDEF);
    op("ld20_h",      1, 0, 1, W, 32'h20,  32'h0, 32'hAB34CDEF, 0, 0, 0, 32'h0);
    op("lb23_s",      1, 0, 1, BS, 32'h23, 32'h0, 32'hFFFFFFAB, 0, 0, 0, 32'h0);
    op("lb23_u",      1, 0, 1, BU, 32'h23, 32'h0, 32'h000000AB, 0, 0, 0, 32'h0);
    op("lh22_s",      1, 0, 1, HS, 32'h22, 32'h0, 32'hFFFFAB34, 0, 0, 0, 32'h0);
    op("lh20_u",      1, 0, 1, HU, 32'h20, 32'h0, 32'h0000CDEF, 0, 0, 0, 32'h0);
    op("lb20_u",      1, 0, 1, BU, 32'h20, 32'h0, 32'h000000EF, 0, 0, 0, 32'h0);
    op("lb21_s",      1, 0, 1, BS, 32'h21, 32'h0, 32'hFFFFFFCD, 0, 0, 0, 32'h0);
    op("sw22_mis",    1, 1, 0, W, 32'h22,  32'hFFFFFFFF, 32'h0, 1, 0, 0, 32'h0);
    op("ld20_keep",   1, 0, 1, W, 32'h20,  32'h0, 32'hAB34CDEF, 0, 0, 0, 32'h0);
    op("lh21_mis",    1, 0, 1, HU, 32'h21, 32'h0, 32'h0, 0, 1, 0, 32'h0);
    op("sw1000_oor",  1, 1, 0, W, 32'h1000, 32'h11111111, 32'h0, 1, 0, 0, 32'h0);
    op("lw1000_oor",  1, 0, 1, W, 32'h1000, 32'h0, 32'h0, 0, 1, 0, 32'h0);
    op("ld_op101",    1, 0, 1, 3'b101, 32'h0, 32'h0, 32'h0, 0, 1, 0, 32'h0);
    op("st_op111",    1, 1, 0, 3'b111, 32'h0, 32'h22222222, 32'h0, 1, 0, 0, 32'h0);
    op("rw22_both",   1, 1, 1, W, 32'h22,  32'h33333333, 32'h0, 1, 1, 0, 32'h0);
    op("rw20_same",   1, 1, 1, W, 32'h20,  32'h11112222, 32'hAB34CDEF, 0, 0, 1, 32'h11112222);
    op("ld20_next",   1, 0, 1, W, 32'h20,  32'h0, 32'h11112222, 0, 0, 0, 32'h0);
    op("swffc_top",   1, 1, 0, W, 32'hFFC, 32'hCAFEF00D, 32'h0, 0, 0, 1, 32'hCAFEF00D);
    op("lwffc_top",   1, 0, 1, W, 32'hFFC, 32'h0, 32'hCAFEF00D, 0, 0, 0, 32'h0);
    op("lbfff_top",   1, 0, 1, BU, 32'hFFF, 32'h0, 32'h000000CA, 0, 0, 0, 32'h0);
    op("sh02_hi",     1, 1, 0, HS, 32'h2,  32'h9999BEEF, 32'h0, 0, 0, 1, 32'hBEEF0000);
    op("ld00_hi",     1, 0, 1, W, 32'h0,   32'h0, 32'hBEEF0000, 0, 0, 0, 32'h0);
    op("rst_st04",    0, 1, 0, W, 32'h4,   32'h00000055, 32'h0, 0, 0, 0, 32'h0);
    op("ld04_clr",    1, 0, 1, W, 32'h4,   32'h0, 32'h0, 0, 0, 0, 32'h0);
    op("ld20_clr",    1, 0, 1, W, 32'h20,  32'h0, 32'h0, 0, 0, 0, 32'h0);

    @(negedge clk);
    mem_write = 1'b0; mem_read = 1'b0;
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge clk);
    #3;
    n_chk++;
    if (exp_q.size() == 0 && tr_q.size() == 0) n_pass++;
    else $display("FAIL drain: got %0d responses and %0d traces outstanding, want 0 and 0",
                  exp_q.size(), tr_q.size());
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
